// File: rtl/mem_arbiter.sv
// Multi-master memory arbiter: grants one master at a time to a single downstream
// memory port, with round-robin or fixed-priority selection and burst support.
module mem_arbiter #(
   parameter int NMASTERS = 2,
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int RR_EN    = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NMASTERS*AW-1:0] m_a,
   input  logic [NMASTERS*DW-1:0] m_d,
   input  logic [NMASTERS-1:0]    m_we,
   input  logic [NMASTERS-1:0]    m_rd,
   input  logic [NMASTERS-1:0]    m_burst_en,
   input  logic [NMASTERS*8-1:0]  m_burst_length,
   output logic [DW-1:0]          m_spo,
   output logic [NMASTERS-1:0]    m_ready,
   output logic [AW-1:0]          s_a,
   output logic [DW-1:0]          s_d,
   output logic                   s_we,
   output logic                   s_rd,
   output logic                   s_burst_en,
   output logic [7:0]             s_burst_length,
   input  logic [DW-1:0]          s_spo,
   input  logic                   s_ready,
   output logic [2:0]             grant_id,
   output logic                   busy,
   output logic [1:0]             dbg_state_o
);

   // Handshake: a master raises m_we/m_rd and holds it until it sees m_ready for
   // its final beat; m_ready is a single-cycle pulse mirroring s_ready while the
   // master owns the port. The downstream port sees s_we/s_rd as a request held
   // until s_ready; any cycle with s_ready high while requesting completes a beat.

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OWN     = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic   [2:0]         grant_q, grant_d;
   logic   [2:0]         last_q, last_d;
   logic   [7:0]         cnt_q, cnt_d;
   logic                 busy_q, busy_d;

   logic   [NMASTERS-1:0] req;
   logic                  win_found;
   logic   [2:0]          win_idx;
   logic                  hi_found, lo_found;
   logic   [2:0]          hi_idx, lo_idx;

   logic   [AW-1:0]       sel_a;
   logic   [DW-1:0]       sel_d;
   logic                  sel_we, sel_rd, sel_ben, sel_req;
   logic   [7:0]          sel_blen;
   logic   [7:0]          eff_len;
   logic                  last_beat;

   assign req = m_we | m_rd;

   // hi_* holds the lowest requester above last_grant, lo_* the lowest at or
   // below it; round-robin prefers hi (the wrap-around search order).
   always_comb begin
      hi_found  = 1'b0;
      lo_found  = 1'b0;
      hi_idx    = 3'd0;
      lo_idx    = 3'd0;
      win_found = 1'b0;
      win_idx   = 3'd0;
      for (int i = NMASTERS - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (3'(i) > last_q) begin
               hi_found = 1'b1;
               hi_idx   = 3'(i);
            end else begin
               lo_found = 1'b1;
               lo_idx   = 3'(i);
            end
         end
      end
      win_found = hi_found | lo_found;
      if (RR_EN != 0) begin
         win_idx = hi_found ? hi_idx : lo_idx;
      end else begin
         win_idx = lo_found ? lo_idx : hi_idx;
      end
   end

   always_comb begin
      sel_a    = '0;
      sel_d    = '0;
      sel_we   = 1'b0;
      sel_rd   = 1'b0;
      sel_ben  = 1'b0;
      sel_blen = 8'd0;
      for (int i = 0; i < NMASTERS; i++) begin
         if (grant_q == 3'(i)) begin
            sel_a    = m_a[i*AW +: AW];
            sel_d    = m_d[i*DW +: DW];
            sel_we   = m_we[i];
            sel_rd   = m_rd[i];
            sel_ben  = m_burst_en[i];
            sel_blen = m_burst_length[i*8 +: 8];
         end
      end
   end

   assign sel_req   = sel_we | sel_rd;
   assign eff_len   = (sel_ben && (sel_blen != 8'd0)) ? sel_blen : 8'd1;
   assign last_beat = (cnt_q == (eff_len - 8'd1));

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_d         = last_q;
      cnt_d          = cnt_q;
      busy_d         = busy_q;
      m_ready        = '0;
      s_a            = '0;
      s_d            = '0;
      s_we           = 1'b0;
      s_rd           = 1'b0;
      s_burst_en     = 1'b0;
      s_burst_length = 8'd0;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant_d = win_idx;
               last_d  = win_idx;
               cnt_d   = 8'd0;
               busy_d  = 1'b1;
               state_d = ST_OWN;
            end
         end
         ST_OWN: begin
            s_a            = sel_a;
            s_d            = sel_d;
            s_we           = sel_we;
            s_rd           = sel_rd;
            s_burst_en     = sel_ben;
            s_burst_length = sel_blen;
            if (!sel_req) begin
               // Owner withdrew mid-access: abandon without delivering a ready.
               state_d = ST_RELEASE;
               busy_d  = 1'b0;
            end else if (s_ready) begin
               // Gating with rstn keeps a beat from leaking out on a reset edge.
               for (int i = 0; i < NMASTERS; i++) begin
                  m_ready[i] = rstn && (grant_q == 3'(i));
               end
               if (last_beat) begin
                  state_d = ST_RELEASE;
                  busy_d  = 1'b0;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         grant_q <= 3'd0;
         last_q  <= 3'(NMASTERS - 1);
         cnt_q   <= 8'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign m_spo       = s_spo;
   assign grant_id    = grant_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 4-master round-robin instance and a 2-master
// fixed-priority instance, driven cycle by cycle from a single process.
module tb_mem_arbiter;

   localparam int NM = 4;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int EW = DW + 3;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // Round-robin instance
   logic [NM*AW-1:0] m_a;
   logic [NM*DW-1:0] m_d;
   logic [NM-1:0]    m_we, m_rd, m_ben;
   logic [NM*8-1:0]  m_blen;
   logic [DW-1:0]    m_spo;
   logic [NM-1:0]    m_ready;
   logic [AW-1:0]    s_a;
   logic [DW-1:0]    s_d;
   logic             s_we, s_rd, s_ben;
   logic [7:0]       s_blen;
   logic [DW-1:0]    s_spo;
   logic             s_ready;
   logic [2:0]       grant_id;
   logic             busy;
   logic [1:0]       dbg_state;

   // Fixed-priority instance
   logic [2*AW-1:0]  f_m_a;
   logic [2*DW-1:0]  f_m_d;
   logic [1:0]       f_m_we, f_m_rd, f_m_ben;
   logic [15:0]      f_m_blen;
   logic [DW-1:0]    f_m_spo;
   logic [1:0]       f_m_ready;
   logic [AW-1:0]    f_s_a;
   logic [DW-1:0]    f_s_d;
   logic             f_s_we, f_s_rd, f_s_ben;
   logic [7:0]       f_s_blen;
   logic [DW-1:0]    f_s_spo;
   logic             f_s_ready;
   logic [2:0]       f_grant_id;
   logic             f_busy;
   logic [1:0]       f_dbg_state;

   mem_arbiter #(.NMASTERS(NM), .AW(AW), .DW(DW), .RR_EN(1)) u_rr (
      .clk(clk), .rstn(rstn), .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_rd(m_rd),
      .m_burst_en(m_ben), .m_burst_length(m_blen), .m_spo(m_spo), .m_ready(m_ready),
      .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd), .s_burst_en(s_ben),
      .s_burst_length(s_blen), .s_spo(s_spo), .s_ready(s_ready),
      .grant_id(grant_id), .busy(busy), .dbg_state_o(dbg_state)
   );

   mem_arbiter #(.NMASTERS(2), .AW(AW), .DW(DW), .RR_EN(0)) u_fp (
      .clk(clk), .rstn(rstn), .m_a(f_m_a), .m_d(f_m_d), .m_we(f_m_we), .m_rd(f_m_rd),
      .m_burst_en(f_m_ben), .m_burst_length(f_m_blen), .m_spo(f_m_spo), .m_ready(f_m_ready),
      .s_a(f_s_a), .s_d(f_s_d), .s_we(f_s_we), .s_rd(f_s_rd), .s_burst_en(f_s_ben),
      .s_burst_length(f_s_blen), .s_spo(f_s_spo), .s_ready(f_s_ready),
      .grant_id(f_grant_id), .busy(f_busy), .dbg_state_o(f_dbg_state)
   );

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   int         pending[NM];
   int         beats[NM];
   logic [NM-1:0] we_sel, drop;
   logic [15:0]   rdy_mask;
   logic          rst_next;
   int            own_cyc, sbeat;
   logic [1:0]    f_req;
   int            f_cnt[2];

   typedef struct {
      int         pend[4];
      logic [3:0] ben;
      logic [3:0] we;
      int         blen[4];
      logic [15:0] mask;
      int         n;
      int         order[8];
   } vec_t;
   vec_t vecs[6];

   function automatic logic [AW-1:0] addr_of(input int i);
      return 16'((i + 1) << 12);
   endfunction

   function automatic int eff(input int i);
      logic [7:0] l;
      l = m_blen[i*8 +: 8];
      return (m_ben[i] && (l != 8'd0)) ? int'(l) : 1;
   endfunction

   function automatic logic pend_any();
      logic r;
      r = 1'b0;
      for (int i = 0; i < NM; i++) if (pending[i] > 0) r = 1'b1;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic push_txn(input int id);
      for (int b = 0; b < eff(id); b++) exp_q.push_back({3'(id), 16'(addr_of(id) + 16'(b))});
   endtask

   // One clock: masters drive at +1, slave models respond at +2, outputs sampled at negedge.
   task automatic step();
      logic [EW-1:0] e;
      @(posedge clk);
      #1;
      rstn = rst_next;
      for (int i = 0; i < NM; i++) begin
         m_rd[i] = (pending[i] > 0) && !drop[i] && !we_sel[i];
         m_we[i] = (pending[i] > 0) && !drop[i] && we_sel[i];
      end
      f_m_rd = f_req;
      #1;
      if (s_rd || s_we) begin
         if (s_ready) sbeat++;
         own_cyc++;
      end else begin
         own_cyc = 0;
         sbeat   = 0;
      end
      s_ready   = (own_cyc > 0) && rdy_mask[own_cyc[3:0]];
      s_spo     = s_a + 16'(sbeat);
      f_s_ready = f_s_rd | f_s_we;
      f_s_spo   = f_s_a;
      @(negedge clk);
      for (int i = 0; i < NM; i++) begin
         if (m_ready[i]) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: ready from master %0d data %0h, required none", i, m_spo);
            end else begin
               e = exp_q.pop_front();
               if (e !== {3'(i), m_spo}) begin
                  errors++;
                  $display("FAIL sb_order: got master %0d data %0h, required master %0d data %0h",
                           i, m_spo, e[EW-1:DW], e[DW-1:0]);
               end
            end
            beats[i]++;
            if (beats[i] >= eff(i)) begin
               beats[i] = 0;
               if (pending[i] > 0) pending[i]--;
            end
         end
      end
      for (int i = 0; i < 2; i++) if (f_m_ready[i]) f_cnt[i]++;
   endtask

   task automatic do_reset();
      for (int i = 0; i < NM; i++) begin
         pending[i] = 0;
         beats[i]   = 0;
      end
      we_sel   = '0;
      drop     = '0;
      m_ben    = '0;
      m_blen   = '0;
      rdy_mask = 16'hFFFF;
      f_req    = 2'b00;
      exp_q.delete();
      rst_next = 1'b0;
      step();
      step();
      rst_next = 1'b1;
      step();
   endtask

   task automatic run_idle(input string name);
      int n;
      n = 0;
      while ((pend_any() || dbg_state != 2'd0) && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s_timeout: still active after %0d cycles, required idle", name, n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_we = '0; m_rd = '0; m_ben = '0; m_blen = '0;
      s_spo = '0; s_ready = 1'b0;
      for (int i = 0; i < NM; i++) begin
         m_a[i*AW +: AW] = addr_of(i);
         m_d[i*DW +: DW] = 16'hD000 + 16'(i);
      end
      f_m_a = {16'h2200, 16'h2100};
      f_m_d = '0; f_m_we = '0; f_m_rd = '0; f_m_ben = '0; f_m_blen = '0;
      f_s_spo = '0; f_s_ready = 1'b0;
      own_cyc = 0; sbeat = 0; f_cnt[0] = 0; f_cnt[1] = 0;
      rst_next = 1'b0;

      vecs[0].pend = '{3, 3, 0, 0}; vecs[0].ben = 4'b0000; vecs[0].we = 4'b0000;
      vecs[0].blen = '{0, 0, 0, 0}; vecs[0].mask = 16'hFFFF; vecs[0].n = 6;
      vecs[0].order = '{0, 1, 0, 1, 0, 1, 0, 0};
      vecs[1].pend = '{0, 1, 1, 0}; vecs[1].ben = 4'b0000; vecs[1].we = 4'b0000;
      vecs[1].blen = '{0, 0, 0, 0}; vecs[1].mask = 16'hFFFF; vecs[1].n = 2;
      vecs[1].order = '{1, 2, 0, 0, 0, 0, 0, 0};
      vecs[2].pend = '{1, 0, 2, 1}; vecs[2].ben = 4'b0000; vecs[2].we = 4'b0100;
      vecs[2].blen = '{0, 0, 0, 0}; vecs[2].mask = 16'hFFFF; vecs[2].n = 4;
      vecs[2].order = '{0, 2, 3, 2, 0, 0, 0, 0};
      vecs[3].pend = '{1, 1, 0, 0}; vecs[3].ben = 4'b0010; vecs[3].we = 4'b0000;
      vecs[3].blen = '{0, 4, 0, 0}; vecs[3].mask = 16'h012C; vecs[3].n = 2;
      vecs[3].order = '{0, 1, 0, 0, 0, 0, 0, 0};
      vecs[4].pend = '{0, 0, 1, 1}; vecs[4].ben = 4'b0100; vecs[4].we = 4'b0000;
      vecs[4].blen = '{0, 0, 0, 5}; vecs[4].mask = 16'hFFFF; vecs[4].n = 2;
      vecs[4].order = '{2, 3, 0, 0, 0, 0, 0, 0};
      vecs[5].pend = '{1, 0, 0, 1}; vecs[5].ben = 4'b1001; vecs[5].we = 4'b1000;
      vecs[5].blen = '{3, 0, 0, 2}; vecs[5].mask = 16'hFFFF; vecs[5].n = 2;
      vecs[5].order = '{0, 3, 0, 0, 0, 0, 0, 0};

      // Reset state
      do_reset();
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_ready", 32'(m_ready), 32'd0);
      check("rst_s_req", 32'({s_we, s_rd}), 32'd0);
      check("rst_s_a", 32'(s_a), 32'd0);

      // Single write: latency, forwarding and three-cycle turnaround
      we_sel[2] = 1'b1;
      m_ben[2] = 1'b1;
      m_blen[2*8 +: 8] = 8'd1;
      push_txn(2);
      pending[2] = 1;
      step();
      check("lat_idle_we", 32'(s_we), 32'd0);
      check("lat_idle_busy", 32'(busy), 32'd0);
      step();
      check("lat_own_state", 32'(dbg_state), 32'd1);
      check("lat_own_we", 32'(s_we), 32'd1);
      check("lat_own_rd", 32'(s_rd), 32'd0);
      check("lat_own_a", 32'(s_a), 32'(addr_of(2)));
      check("lat_own_d", 32'(s_d), 32'hD002);
      check("lat_own_ben", 32'(s_ben), 32'd1);
      check("lat_own_blen", 32'(s_blen), 32'd1);
      check("lat_own_grant", 32'(grant_id), 32'd2);
      check("lat_own_busy", 32'(busy), 32'd1);
      step();
      check("lat_rel_state", 32'(dbg_state), 32'd2);
      check("lat_rel_we", 32'(s_we), 32'd0);
      check("lat_rel_busy", 32'(busy), 32'd0);
      step();
      check("lat_idle2_state", 32'(dbg_state), 32'd0);
      check("lat_left", 32'(exp_q.size()), 32'd0);

      // Table-driven arbitration and burst vectors
      for (int v = 0; v < 6; v++) begin
         do_reset();
         rdy_mask = vecs[v].mask;
         for (int i = 0; i < NM; i++) begin
            m_ben[i]          = vecs[v].ben[i];
            we_sel[i]         = vecs[v].we[i];
            m_blen[i*8 +: 8]  = 8'(vecs[v].blen[i]);
         end
         for (int k = 0; k < vecs[v].n; k++) push_txn(vecs[v].order[k]);
         for (int i = 0; i < NM; i++) pending[i] = vecs[v].pend[i];
         run_idle($sformatf("vec%0d", v));
         check($sformatf("vec%0d_left", v), 32'(exp_q.size()), 32'd0);
      end

      // Abort: owner drops its request before any ready
      do_reset();
      rdy_mask = 16'h0008;
      pending[1] = 1;
      step();
      step();
      check("abort_own", 32'(dbg_state), 32'd1);
      drop[1] = 1'b1;
      step();
      check("abort_s_rd", 32'(s_rd), 32'd0);
      check("abort_no_ready", 32'(m_ready), 32'd0);
      step();
      check("abort_release", 32'(dbg_state), 32'd2);
      check("abort_busy", 32'(busy), 32'd0);
      pending[1] = 0;
      drop[1] = 1'b0;
      step();
      check("abort_idle", 32'(dbg_state), 32'd0);

      // Reset during ownership with the slave ready on the same edge
      do_reset();
      pending[1] = 1;
      step();
      rst_next = 1'b0;
      step();
      check("rstown_state", 32'(dbg_state), 32'd1);
      check("rstown_no_ready", 32'(m_ready), 32'd0);
      pending[0] = 1;
      rst_next = 1'b1;
      step();
      check("rstown_idle", 32'(dbg_state), 32'd0);
      check("rstown_busy", 32'(busy), 32'd0);
      check("rstown_s_rd", 32'(s_rd), 32'd0);
      push_txn(0);
      push_txn(1);
      run_idle("rstown");
      check("rstown_left", 32'(exp_q.size()), 32'd0);

      // Fixed priority: master 1 starves while master 0 keeps requesting
      do_reset();
      f_cnt[0] = 0;
      f_cnt[1] = 0;
      f_req = 2'b11;
      for (int c = 0; c < 30; c++) step();
      check("fp_m0_count", 32'(f_cnt[0]), 32'd10);
      check("fp_m1_starved", 32'(f_cnt[1]), 32'd0);
      f_req = 2'b10;
      for (int c = 0; c < 10 && f_cnt[1] == 0; c++) step();
      check("fp_m1_served", 32'(f_cnt[1] > 0), 32'd1);
      f_req = 2'b00;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
